// File: rtl/markov_defs_pkg.sv
// Shared definitions for the first-order Markov build and merge stages:
// default widths, list entry layout and the build FSM state encoding.
package markov_defs;

    localparam int NOTE_W  = 8;
    localparam int CNT_W   = 8;
    localparam int ENTRY_W = 2*NOTE_W + CNT_W;

    localparam int CNT_LSB  = 0;
    localparam int NEXT_LSB = CNT_W;
    localparam int PREV_LSB = CNT_W + NOTE_W;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic [NOTE_W-1:0] prev;
        logic [NOTE_W-1:0] next;
        logic [CNT_W-1:0]  count;
    } entry_t;

    function automatic logic [ENTRY_W-1:0] pack_entry(entry_t e);
        return {e.prev, e.next, e.count};
    endfunction

    function automatic entry_t unpack_entry(logic [ENTRY_W-1:0] v);
        entry_t e;
        e.prev  = v[PREV_LSB +: NOTE_W];
        e.next  = v[NEXT_LSB +: NOTE_W];
        e.count = v[CNT_LSB  +: CNT_W];
        return e;
    endfunction

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD_PREV,
        S_LOAD_NEXT,
        S_SEARCH,
        S_COMPARE,
        S_INCREMENT,
        S_APPEND,
        S_ADVANCE,
        S_FINISH
    } state_t;

endpackage

// File: rtl/markov_first_build.sv
// Builds a first-order transition list {prev,next,count} from a note sequence,
// one list write per adjacent pair, entries kept in first-occurrence order.
module markov_first_build #(
    parameter int NOTE_W  = markov_defs::NOTE_W,
    parameter int CNT_W   = markov_defs::CNT_W,
    parameter int SEQ_AW  = 8,
    parameter int LIST_AW = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [SEQ_AW:0]             seq_len,
    output logic [SEQ_AW-1:0]           seq_addr,
    input  logic [NOTE_W-1:0]           seq_rdata,
    output logic [LIST_AW-1:0]          list_addr,
    output logic                        list_we,
    output logic [2*NOTE_W+CNT_W-1:0]   list_wdata,
    input  logic [2*NOTE_W+CNT_W-1:0]   list_rdata,
    output logic [LIST_AW:0]            list_len,
    output logic                        overflow,
    output logic                        busy,
    output logic                        done,
    output markov_defs::state_t         dbg_state
);
    import markov_defs::*;

    localparam int EW = 2*NOTE_W + CNT_W;
    localparam logic [CNT_W-1:0]   CNT_TOP  = '1;
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [LIST_AW:0]   LIST_CAP = {1'b1, {LIST_AW{1'b0}}};
    localparam logic [LIST_AW:0]   J_ONE    = (LIST_AW+1)'(1);
    localparam logic [SEQ_AW:0]    I_ONE    = (SEQ_AW+1)'(1);
    localparam logic [SEQ_AW:0]    SEQ_TWO  = (SEQ_AW+1)'(2);
    localparam logic [SEQ_AW-1:0]  ADDR_ONE = SEQ_AW'(1);
    localparam logic [SEQ_AW+1:0]  I_TWO    = (SEQ_AW+2)'(2);

    state_t              state, state_nx;
    logic [SEQ_AW:0]     len_q;
    logic [SEQ_AW:0]     i_q;
    logic [LIST_AW:0]    j_q;
    logic [NOTE_W-1:0]   prev_q, next_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                hit;
    logic                last_pair;
    logic [SEQ_AW+1:0]   i_plus2;

    assign hit       = (list_rdata[EW-1 -: NOTE_W] == prev_q) &&
                       (list_rdata[CNT_W +: NOTE_W] == next_q);
    assign i_plus2   = {1'b0, i_q} + I_TWO;
    assign last_pair = (i_plus2 == {1'b0, len_q});
    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:      if (start) state_nx = (seq_len >= SEQ_TWO) ? S_LOAD_PREV : S_FINISH;
            S_LOAD_PREV: state_nx = S_LOAD_NEXT;
            S_LOAD_NEXT: state_nx = S_SEARCH;
            S_SEARCH:    state_nx = (j_q == list_len) ? S_APPEND : S_COMPARE;
            S_COMPARE:   state_nx = hit ? S_INCREMENT : S_SEARCH;
            S_INCREMENT: state_nx = S_ADVANCE;
            S_APPEND:    state_nx = S_ADVANCE;
            S_ADVANCE:   state_nx = last_pair ? S_FINISH : S_LOAD_NEXT;
            S_FINISH:    state_nx = S_IDLE;
            default:     state_nx = S_IDLE;
        endcase
    end

    // prev arrives during the first LOAD_NEXT; next arrives in the SEARCH entered
    // from LOAD_NEXT, the only time SEARCH sees j==0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q    <= '0;
            i_q      <= '0;
            j_q      <= '0;
            prev_q   <= '0;
            next_q   <= '0;
            cnt_q    <= '0;
            list_len <= '0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    len_q    <= seq_len;
                    i_q      <= '0;
                    list_len <= '0;
                    overflow <= 1'b0;
                    done     <= 1'b0;
                    busy     <= 1'b1;
                end
                S_LOAD_NEXT: begin
                    j_q <= '0;
                    if (i_q == '0) prev_q <= seq_rdata;
                end
                S_SEARCH: if (j_q == '0) next_q <= seq_rdata;
                S_COMPARE: begin
                    if (hit) cnt_q <= list_rdata[CNT_W-1:0];
                    else     j_q   <= j_q + J_ONE;
                end
                S_APPEND: begin
                    if (list_len < LIST_CAP) list_len <= list_len + J_ONE;
                    else                     overflow <= 1'b1;
                end
                S_ADVANCE: begin
                    prev_q <= next_q;
                    i_q    <= i_q + I_ONE;
                end
                S_FINISH: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        seq_addr   = '0;
        list_addr  = '0;
        list_we    = 1'b0;
        list_wdata = '0;
        case (state)
            S_LOAD_NEXT: seq_addr  = i_q[SEQ_AW-1:0] + ADDR_ONE;
            S_SEARCH:    list_addr = j_q[LIST_AW-1:0];
            S_COMPARE:   list_addr = j_q[LIST_AW-1:0];
            S_INCREMENT: begin
                list_we    = 1'b1;
                list_addr  = j_q[LIST_AW-1:0];
                list_wdata = {prev_q, next_q, (cnt_q == CNT_TOP) ? cnt_q : cnt_q + CNT_ONE};
            end
            S_APPEND: if (list_len < LIST_CAP) begin
                list_we    = 1'b1;
                list_addr  = list_len[LIST_AW-1:0];
                list_wdata = {prev_q, next_q, CNT_ONE};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_markov_first_build.sv
// Bench for markov_first_build: a default-width instance and a narrow one
// (2-bit counts, 2-entry list) driven from sequence tables and random runs.
module tb_markov_first_build;
    import markov_defs::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    int n_checks = 0;
    int n_pass   = 0;

    // instance A: default widths
    logic        start_a;
    logic [8:0]  seq_len_a;
    logic [7:0]  seq_addr_a, seq_rdata_a;
    logic [7:0]  list_addr_a;
    logic        list_we_a;
    logic [23:0] list_wdata_a, list_rdata_a;
    logic [8:0]  list_len_a;
    logic        overflow_a, busy_a, done_a;
    state_t      dbg_a;
    logic [7:0]  seq_mem_a [256];
    logic [23:0] list_mem_a [256];
    logic [31:0] exp_q_a [$];
    int          rises_a;
    logic        done_a_q = 1'b0;

    // instance B: CNT_W=2, LIST_AW=1
    logic        start_b;
    logic [8:0]  seq_len_b;
    logic [7:0]  seq_addr_b, seq_rdata_b;
    logic [0:0]  list_addr_b;
    logic        list_we_b;
    logic [17:0] list_wdata_b, list_rdata_b;
    logic [1:0]  list_len_b;
    logic        overflow_b, busy_b, done_b;
    state_t      dbg_b;
    logic [7:0]  seq_mem_b [256];
    logic [17:0] list_mem_b [2];
    logic [18:0] exp_q_b [$];

    markov_first_build dut_a (
        .clk(clk), .reset(reset), .start(start_a), .seq_len(seq_len_a),
        .seq_addr(seq_addr_a), .seq_rdata(seq_rdata_a), .list_addr(list_addr_a),
        .list_we(list_we_a), .list_wdata(list_wdata_a), .list_rdata(list_rdata_a),
        .list_len(list_len_a), .overflow(overflow_a), .busy(busy_a), .done(done_a),
        .dbg_state(dbg_a)
    );

    markov_first_build #(.CNT_W(2), .LIST_AW(1)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .seq_len(seq_len_b),
        .seq_addr(seq_addr_b), .seq_rdata(seq_rdata_b), .list_addr(list_addr_b),
        .list_we(list_we_b), .list_wdata(list_wdata_b), .list_rdata(list_rdata_b),
        .list_len(list_len_b), .overflow(overflow_b), .busy(busy_b), .done(done_b),
        .dbg_state(dbg_b)
    );

    // synchronous-read RAM models
    always @(posedge clk) begin
        seq_rdata_a  <= seq_mem_a[seq_addr_a];
        list_rdata_a <= list_mem_a[list_addr_a];
        if (list_we_a) list_mem_a[list_addr_a] <= list_wdata_a;
        seq_rdata_b  <= seq_mem_b[seq_addr_b];
        list_rdata_b <= list_mem_b[list_addr_b];
        if (list_we_b) list_mem_b[list_addr_b] <= list_wdata_b;
    end

    // scoreboard: every list write must match the next expected {addr, entry}
    always @(negedge clk) begin
        if (reset === 1'b1 && list_we_a === 1'b1) begin
            n_checks++;
            if (exp_q_a.size() == 0) $display("FAIL wr_a: unexpected write %h", {list_addr_a, list_wdata_a});
            else begin
                logic [31:0] e;
                e = exp_q_a.pop_front();
                if ({list_addr_a, list_wdata_a} !== e) $display("FAIL wr_a: got %h expected %h", {list_addr_a, list_wdata_a}, e);
                else n_pass++;
            end
        end
        if (reset === 1'b1 && list_we_b === 1'b1) begin
            n_checks++;
            if (exp_q_b.size() == 0) $display("FAIL wr_b: unexpected write %h", {list_addr_b, list_wdata_b});
            else begin
                logic [18:0] e;
                e = exp_q_b.pop_front();
                if ({list_addr_b, list_wdata_b} !== e) $display("FAIL wr_b: got %h expected %h", {list_addr_b, list_wdata_b}, e);
                else n_pass++;
            end
        end
        if (done_a === 1'b1 && done_a_q !== 1'b1) rises_a++;
        done_a_q = done_a;
    end

    // behavioural reference: list, overflow and the ordered write stream
    int          m_p[$], m_n[$], m_c[$];
    int          m_ovf;
    logic [31:0] m_wr[$];

    task automatic model(input int seq[$], input int cnt_max, input int cap, input bit fmt_b);
        m_p.delete(); m_n.delete(); m_c.delete(); m_wr.delete(); m_ovf = 0;
        for (int k = 0; k + 1 < seq.size(); k++) begin
            int p, n, idx;
            p = seq[k]; n = seq[k+1]; idx = -1;
            for (int e = 0; e < m_p.size(); e++) if (m_p[e] == p && m_n[e] == n) idx = e;
            if (idx < 0 && m_p.size() < cap) begin
                m_p.push_back(p); m_n.push_back(n); m_c.push_back(0);
                idx = m_p.size() - 1;
            end
            if (idx < 0) m_ovf = 1;
            else begin
                if (m_c[idx] < cnt_max) m_c[idx]++;
                if (fmt_b) m_wr.push_back(32'((idx << 18) | (p << 10) | (n << 2) | m_c[idx]));
                else       m_wr.push_back(32'((idx << 24) | (p << 16) | (n << 8) | m_c[idx]));
            end
        end
    endtask

    task automatic prep_a(input int seq[$]);
        foreach (seq[k]) seq_mem_a[k] = 8'(seq[k]);
        seq_len_a = 9'(seq.size());
        model(seq, 255, 256, 1'b0);
        exp_q_a.delete();
        foreach (m_wr[k]) exp_q_a.push_back(m_wr[k]);
    endtask

    task automatic run_a(input int seq[$], input int glitch_at, output int cyc);
        prep_a(seq);
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        rises_a = 0;
        n_checks++;
        if ({busy_a, done_a} !== 2'b10) $display("FAIL busy_a after start: got %b expected 10", {busy_a, done_a});
        else n_pass++;
        cyc = 0;
        while (done_a !== 1'b1 && cyc < 20000) begin
            if (cyc == glitch_at) begin start_a = 1'b1; seq_len_a = 9'd2; end
            else start_a = 1'b0;
            @(negedge clk);
            cyc++;
        end
        start_a = 1'b0;
        n_checks++;
        if (done_a !== 1'b1) $display("FAIL done_a timeout: got %b expected 1", done_a);
        else n_pass++;
        n_checks++;
        if (busy_a !== 1'b0) $display("FAIL busy_a at done: got %b expected 0", busy_a);
        else n_pass++;
        n_checks++;
        if (list_len_a !== 9'(m_p.size())) $display("FAIL list_len_a: got %0d expected %0d", list_len_a, m_p.size());
        else n_pass++;
        n_checks++;
        if (overflow_a !== 1'(m_ovf)) $display("FAIL overflow_a: got %b expected %0d", overflow_a, m_ovf);
        else n_pass++;
        n_checks++;
        if (exp_q_a.size() != 0) $display("FAIL missing_wr_a: got %0d pending expected 0", exp_q_a.size());
        else n_pass++;
        for (int k = 0; k < m_p.size(); k++) begin
            logic [23:0] ee;
            ee = {8'(m_p[k]), 8'(m_n[k]), 8'(m_c[k])};
            n_checks++;
            if (list_mem_a[k] !== ee) $display("FAIL entry_a[%0d]: got %h expected %h", k, list_mem_a[k], ee);
            else n_pass++;
        end
    endtask

    task automatic run_b(input int seq[$]);
        int cyc;
        foreach (seq[k]) seq_mem_b[k] = 8'(seq[k]);
        seq_len_b = 9'(seq.size());
        model(seq, 3, 2, 1'b1);
        exp_q_b.delete();
        foreach (m_wr[k]) exp_q_b.push_back(19'(m_wr[k]));
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        cyc = 0;
        while (done_b !== 1'b1 && cyc < 20000) begin @(negedge clk); cyc++; end
        n_checks++;
        if (done_b !== 1'b1) $display("FAIL done_b timeout: got %b expected 1", done_b);
        else n_pass++;
        n_checks++;
        if (list_len_b !== 2'(m_p.size())) $display("FAIL list_len_b: got %0d expected %0d", list_len_b, m_p.size());
        else n_pass++;
        n_checks++;
        if (overflow_b !== 1'(m_ovf)) $display("FAIL overflow_b: got %b expected %0d", overflow_b, m_ovf);
        else n_pass++;
        n_checks++;
        if (exp_q_b.size() != 0) $display("FAIL missing_wr_b: got %0d pending expected 0", exp_q_b.size());
        else n_pass++;
        for (int k = 0; k < m_p.size(); k++) begin
            logic [17:0] ee;
            ee = {8'(m_p[k]), 8'(m_n[k]), 2'(m_c[k])};
            n_checks++;
            if (list_mem_b[k] !== ee) $display("FAIL entry_b[%0d]: got %h expected %h", k, list_mem_b[k], ee);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start_a = 1'b0; start_b = 1'b0;
        seq_len_a = '0; seq_len_b = '0;
        foreach (seq_mem_a[k]) seq_mem_a[k] = '0;
        foreach (seq_mem_b[k]) seq_mem_b[k] = '0;
        foreach (list_mem_a[k]) list_mem_a[k] = '0;
        foreach (list_mem_b[k]) list_mem_b[k] = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({seq_addr_a, list_addr_a, list_we_a, list_wdata_a, list_len_a, overflow_a, busy_a, done_a, dbg_a} !== '0)
            $display("FAIL reset_a: got %h expected 0", {seq_addr_a, list_addr_a, list_we_a, list_wdata_a, list_len_a, overflow_a, busy_a, done_a, dbg_a});
        else n_pass++;
        n_checks++;
        if ({seq_addr_b, list_addr_b, list_we_b, list_wdata_b, list_len_b, overflow_b, busy_b, done_b, dbg_b} !== '0)
            $display("FAIL reset_b: got %h expected 0", {seq_addr_b, list_addr_b, list_we_b, list_wdata_b, list_len_b, overflow_b, busy_b, done_b, dbg_b});
        else n_pass++;
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_pair_counting();
        int s[$]; int cyc;
        s = '{60, 62, 60, 62};
        run_a(s, -1, cyc);
        n_checks++;
        if (list_mem_a[0] !== 24'h3C3E02) $display("FAIL pairs_e0: got %h expected 3c3e02", list_mem_a[0]);
        else n_pass++;
        n_checks++;
        if (list_mem_a[1] !== 24'h3E3C01) $display("FAIL pairs_e1: got %h expected 3e3c01", list_mem_a[1]);
        else n_pass++;
        n_checks++;
        if ({list_len_a, overflow_a, done_a} !== {9'd2, 1'b0, 1'b1}) $display("FAIL pairs_status: got %0d/%b/%b expected 2/0/1", list_len_a, overflow_a, done_a);
        else n_pass++;
    endtask

    task automatic test_no_pairs();
        int s[$]; int cyc;
        s.delete();
        run_a(s, -1, cyc);
        n_checks++;
        if (cyc > 2) $display("FAIL len0_latency: got %0d cycles expected <=2", cyc);
        else n_pass++;
        s.push_back(9);
        run_a(s, -1, cyc);
        n_checks++;
        if (cyc > 2) $display("FAIL len1_latency: got %0d cycles expected <=2", cyc);
        else n_pass++;
        n_checks++;
        if (list_len_a !== 9'd0) $display("FAIL len1_list_len: got %0d expected 0", list_len_a);
        else n_pass++;
    endtask

    task automatic test_saturation();
        int s[$];
        s = '{5, 5, 5, 5, 5, 5};
        run_b(s);
        n_checks++;
        if (list_mem_b[0] !== {8'd5, 8'd5, 2'd3}) $display("FAIL sat_entry: got %h expected %h", list_mem_b[0], {8'd5, 8'd5, 2'd3});
        else n_pass++;
        n_checks++;
        if (list_len_b !== 2'd1) $display("FAIL sat_len: got %0d expected 1", list_len_b);
        else n_pass++;
    endtask

    task automatic test_list_full();
        int s[$];
        s = '{1, 2, 3, 4};
        run_b(s);
        n_checks++;
        if ({list_mem_b[0], list_mem_b[1]} !== {8'd1, 8'd2, 2'd1, 8'd2, 8'd3, 2'd1})
            $display("FAIL full_entries: got %h %h expected %h %h", list_mem_b[0], list_mem_b[1], {8'd1, 8'd2, 2'd1}, {8'd2, 8'd3, 2'd1});
        else n_pass++;
        n_checks++;
        if ({list_len_b, overflow_b} !== {2'd2, 1'b1}) $display("FAIL full_status: got %0d/%b expected 2/1", list_len_b, overflow_b);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int s[$]; int cyc;
        s = '{60, 62, 60, 62};
        prep_a(s);
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        cyc = 0;
        while (!(exp_q_a.size() == 1 && dbg_a == S_COMPARE) && cyc < 200) begin @(negedge clk); cyc++; end
        n_checks++;
        if (dbg_a !== S_COMPARE) $display("FAIL rmid_reach: got state %0d expected %0d", dbg_a, S_COMPARE);
        else n_pass++;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({seq_addr_a, list_addr_a, list_we_a, list_wdata_a, list_len_a, overflow_a, busy_a, done_a, dbg_a} !== '0)
            $display("FAIL rmid_outputs: got %h expected 0", {seq_addr_a, list_addr_a, list_we_a, list_wdata_a, list_len_a, overflow_a, busy_a, done_a, dbg_a});
        else n_pass++;
        exp_q_a.delete();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        s = '{7, 8};
        run_a(s, -1, cyc);
        n_checks++;
        if ({list_mem_a[0], list_len_a} !== {8'd7, 8'd8, 8'd1, 9'd1}) $display("FAIL rmid_fresh: got %h/%0d expected 070801/1", list_mem_a[0], list_len_a);
        else n_pass++;
    endtask

    task automatic test_start_while_busy();
        int s[$]; int cyc;
        s = '{60, 62, 60, 62};
        run_a(s, 4, cyc);
        repeat (3) @(negedge clk);
        n_checks++;
        if ({list_mem_a[0], list_mem_a[1], list_len_a} !== {24'h3C3E02, 24'h3E3C01, 9'd2})
            $display("FAIL busy_start_result: got %h %h %0d expected 3c3e02 3e3c01 2", list_mem_a[0], list_mem_a[1], list_len_a);
        else n_pass++;
        n_checks++;
        if (rises_a !== 1 || done_a !== 1'b1) $display("FAIL busy_start_done: got %0d rises done=%b expected 1 rise done=1", rises_a, done_a);
        else n_pass++;
    endtask

    task automatic test_random();
        int s[$]; int alpha[4]; int cyc;
        for (int r = 0; r < 4; r++) begin
            int n;
            foreach (alpha[k]) alpha[k] = $urandom_range(0, 255);
            n = (r == 3) ? 256 : $urandom_range(2, 60);
            s.delete();
            for (int k = 0; k < n; k++) s.push_back(alpha[$urandom_range(0, 3)]);
            run_a(s, -1, cyc);
        end
        for (int r = 0; r < 3; r++) begin
            int n;
            foreach (alpha[k]) alpha[k] = $urandom_range(0, 255);
            n = $urandom_range(2, 20);
            s.delete();
            for (int k = 0; k < n; k++) s.push_back(alpha[$urandom_range(0, 2)]);
            run_b(s);
        end
    endtask

    initial begin
        test_reset();
        test_pair_counting();
        test_no_pairs();
        test_saturation();
        test_list_full();
        test_reset_mid();
        test_start_while_busy();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
